// File: rtl/arm_bus_gpio_slave.sv
// ARM CS5 bus slave for the TLL6219 interface: synchronises the raw bus, decodes
// strobes by falling edge and exposes NUM_BANKS GPIO banks with edge interrupts.
module arm_bus_gpio_slave #(
  parameter int DW          = 32,
  parameter int AW          = 24,
  parameter int NUM_BANKS   = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [AW-1:0]           addr,
  input  logic [DW-1:0]           din,
  output logic [DW-1:0]           dout,
  output logic                    dout_oe,
  input  logic                    ws_n,
  input  logic                    rs_n,
  input  logic [DW/8-1:0]         be_n,
  input  logic                    as,
  input  logic [NUM_BANKS*DW-1:0] gpio_in,
  output logic [NUM_BANKS*DW-1:0] gpio_out,
  output logic [NUM_BANKS*DW-1:0] gpio_oe,
  output logic                    irq
);

  localparam int NBY = DW / 8;
  localparam int SW  = AW + DW + NBY + 3 + NUM_BANKS * DW;
  localparam logic [3:0] NB4 = 4'(NUM_BANKS);

  // Every asynchronous input travels through one shared chain of SYNC_STAGES flops.
  logic [SW-1:0]                   w_raw;
  logic [SYNC_STAGES-1:0][SW-1:0]  r_sync;

  logic [AW-1:0]                   w_addr_s;
  logic [DW-1:0]                   w_din_s;
  logic [NBY-1:0]                  w_be_n_s;
  logic                            w_ws_n_s;
  logic                            w_rs_n_s;
  logic                            w_as_s;
  logic [NUM_BANKS-1:0][DW-1:0]    w_in_s;

  assign w_raw = {addr, din, be_n, ws_n, rs_n, as, gpio_in};
  assign {w_addr_s, w_din_s, w_be_n_s, w_ws_n_s, w_rs_n_s, w_as_s, w_in_s} = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= w_raw;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  // Access handshake: a strobe is valid for exactly one cycle, on the falling
  // edge of ws_n_s/rs_n_s while as_s is high. There is no ready; every valid
  // strobe is consumed in that cycle. A write strobe suppresses a coincident read.
  logic r_prev_ws, r_prev_rs;
  logic w_wr_stb, w_rd_stb;

  assign w_wr_stb = r_prev_ws & ~w_ws_n_s & w_as_s;
  assign w_rd_stb = r_prev_rs & ~w_rs_n_s & w_as_s & ~w_wr_stb;

  logic [AW-3:0] w_idx;
  logic [2:0]    w_bank;
  logic [2:0]    w_reg;
  logic          w_hit;
  logic          w_unused_addr;

  assign w_idx         = w_addr_s[AW-1:2];
  assign w_bank        = w_idx[5:3];
  assign w_reg         = w_idx[2:0];
  assign w_hit         = (w_idx[AW-3:6] == '0) && ({1'b0, w_bank} < NB4);
  assign w_unused_addr = ^w_addr_s[1:0];

  logic [NUM_BANKS-1:0][DW-1:0] r_out, r_dir, r_en, r_stat, r_in_prev;
  logic [DW-1:0]                r_dout;
  logic                         r_dout_oe;
  logic                         r_irq;

  logic [DW-1:0]                w_bmask;
  logic [NUM_BANKS-1:0]         w_bank_sel;
  logic [NUM_BANKS-1:0][DW-1:0] w_edge, w_clr;
  logic [DW-1:0]                w_rdata;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v,
                                          input logic [DW-1:0] new_v,
                                          input logic [DW-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  always_comb begin
    w_bmask    = '0;
    w_bank_sel = '0;
    w_edge     = '0;
    w_clr      = '0;
    for (int b = 0; b < NBY; b++) w_bmask[b*8 +: 8] = {8{~w_be_n_s[b]}};
    for (int b = 0; b < NUM_BANKS; b++) begin
      w_bank_sel[b] = w_wr_stb & w_hit & (w_bank == 3'(b));
      // Only input-configured bits can raise a status flag.
      w_edge[b]     = w_in_s[b] & ~r_in_prev[b] & ~r_dir[b];
      w_clr[b]      = (w_bank_sel[b] && w_reg == 3'd4) ? (w_din_s & w_bmask) : '0;
    end
  end

  always_comb begin
    w_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (w_hit && w_bank == 3'(b)) begin
        case (w_reg)
          3'd0:    w_rdata = r_out[b];
          3'd1:    w_rdata = r_dir[b];
          3'd2:    w_rdata = w_in_s[b];
          3'd3:    w_rdata = r_en[b];
          3'd4:    w_rdata = r_stat[b];
          default: w_rdata = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prev_ws <= 1'b0;
      r_prev_rs <= 1'b0;
      r_out     <= '0;
      r_dir     <= '0;
      r_en      <= '0;
      r_stat    <= '0;
      r_in_prev <= '0;
      r_dout    <= '0;
      r_dout_oe <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      r_prev_ws <= w_ws_n_s;
      r_prev_rs <= w_rs_n_s;
      for (int b = 0; b < NUM_BANKS; b++) begin
        r_in_prev[b] <= w_in_s[b];
        // A new edge wins over a simultaneous write-1-to-clear.
        r_stat[b]    <= (r_stat[b] & ~w_clr[b]) | w_edge[b];
        if (w_bank_sel[b]) begin
          case (w_reg)
            3'd0:    r_out[b] <= merge(r_out[b], w_din_s, w_bmask);
            3'd1:    r_dir[b] <= merge(r_dir[b], w_din_s, w_bmask);
            3'd3:    r_en[b]  <= merge(r_en[b],  w_din_s, w_bmask);
            default: ;
          endcase
        end
      end
      if (w_rd_stb) r_dout <= w_rdata;
      r_dout_oe <= ~w_rs_n_s & w_as_s;
      r_irq     <= |(r_stat & r_en);
    end
  end

  assign dout     = r_dout;
  assign dout_oe  = r_dout_oe;
  assign irq      = r_irq;
  assign gpio_out = r_out;
  assign gpio_oe  = r_dir;

endmodule

// File: tb/tb_arm_bus_gpio_slave.sv
// Self-checking bench for arm_bus_gpio_slave: bus write/read tasks, a read-data
// scoreboard queue and directed GPIO/interrupt/reset scenarios.
module tb_arm_bus_gpio_slave;

  localparam int DW = 32;
  localparam int AW = 24;
  localparam int NB = 2;
  localparam int SS = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [AW-1:0]    addr;
  logic [DW-1:0]    din;
  logic [DW-1:0]    dout;
  logic             dout_oe;
  logic             ws_n;
  logic             rs_n;
  logic [DW/8-1:0]  be_n;
  logic             as;
  logic [NB*DW-1:0] gpio_in;
  logic [NB*DW-1:0] gpio_out;
  logic [NB*DW-1:0] gpio_oe;
  logic             irq;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  arm_bus_gpio_slave #(.DW(DW), .AW(AW), .NUM_BANKS(NB), .SYNC_STAGES(SS)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .dout(dout), .dout_oe(dout_oe),
    .ws_n(ws_n), .rs_n(rs_n), .be_n(be_n), .as(as), .gpio_in(gpio_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] be, input bit pin_edge);
    @(negedge clk);
    addr = a; din = d; be_n = be; as = 1'b1;
    repeat (3) @(negedge clk);
    ws_n = 1'b0;
    if (pin_edge) gpio_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    ws_n = 1'b1;
    repeat (4) @(negedge clk);
    as = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    bit seen;
    logic [DW-1:0] e;
    @(negedge clk);
    addr = a; as = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back(exp);
    rs_n = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (dout_oe === 1'b1) seen = 1'b1;
    end
    check_val({tag, "_oe"}, 64'(seen), 64'd1);
    e = exp_q.pop_front();
    if (seen) check_val(tag, dout, e);
    rs_n = 1'b1;
    repeat (4) @(negedge clk);
    check_val({tag, "_oe_off"}, dout_oe, 0);
    check_val({tag, "_hold"}, dout, e);
    as = 1'b0;
  endtask

  initial begin
    bit seen;
    rst = 1'b0; addr = '0; din = '0; ws_n = 1'b1; rs_n = 1'b1;
    be_n = '1; as = 1'b0; gpio_in = '0;
    repeat (3) @(negedge clk);
    check_val("rst_dout", dout, 0);
    check_val("rst_dout_oe", dout_oe, 0);
    check_val("rst_irq", irq, 0);
    check_val("rst_gpio_out", gpio_out, 0);
    check_val("rst_gpio_oe", gpio_oe, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // 1: full-word write with exact latency, then read back
    @(negedge clk);
    addr = 24'h000000; din = 32'hDEADBEEF; be_n = 4'b0000; as = 1'b1;
    repeat (3) @(negedge clk);
    ws_n = 1'b0;
    repeat (2) @(negedge clk);
    check_val("t1_out_early", gpio_out[31:0], 0);
    @(negedge clk);
    check_val("t1_out", gpio_out[31:0], 32'hDEADBEEF);
    ws_n = 1'b1;
    repeat (4) @(negedge clk);
    as = 1'b0;
    do_read(24'h000000, 32'hDEADBEEF, "t1_rd");

    // 2: byte-enabled write
    do_write(24'h000000, 32'h11223344, 4'b1010, 1'b0);
    check_val("t2_out", gpio_out[31:0], 32'hDE22BE44);
    do_read(24'h000000, 32'hDE22BE44, "t2_rd");

    // 3: direction and input capture
    do_write(24'h000024, 32'h0000FFFF, 4'b0000, 1'b0);
    gpio_in[63:32] = 32'hA5A5A5A5;
    repeat (SS + 1) @(negedge clk);
    check_val("t3_oe_b1", gpio_oe[63:32], 32'h0000FFFF);
    check_val("t3_oe_b0", gpio_oe[31:0], 0);
    check_val("t3_out_b1", gpio_out[63:32], 0);
    do_read(24'h000028, 32'hA5A5A5A5, "t3_in_b1");

    // 4: interrupt set, clear, and set-beats-clear
    do_write(24'h00000C, 32'h00000001, 4'b0000, 1'b0);
    check_val("t4_irq_idle", irq, 0);
    gpio_in[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < SS + 2 && !seen; i++) begin
      @(negedge clk);
      if (irq === 1'b1) seen = 1'b1;
    end
    check_val("t4_irq_rise", 64'(seen), 64'd1);
    do_read(24'h000010, 32'h00000001, "t4_stat");
    do_read(24'h000030, 32'hA5A50000, "t4_stat_b1");
    do_write(24'h000010, 32'h00000001, 4'b0000, 1'b0);
    check_val("t4_irq_clr", irq, 0);
    do_read(24'h000010, 32'h00000000, "t4_stat_clr");
    gpio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    do_write(24'h000010, 32'h00000001, 4'b0000, 1'b1);
    check_val("t4_irq_setwin", irq, 1);
    do_read(24'h000010, 32'h00000001, "t4_stat_setwin");

    // 5: unmapped accesses and strobe rules
    do_read(24'h00001C, 32'h0, "t5_reg7");
    do_read(24'h0000A0, 32'h0, "t5_bank5");
    do_read(24'h000100, 32'h0, "t5_hi_bits");
    do_write(24'h000028, 32'hFFFFFFFF, 4'b0000, 1'b0);
    do_read(24'h000028, 32'hA5A5A5A5, "t5_in_ro");
    do_write(24'h0000A0, 32'h12345678, 4'b0000, 1'b0);
    check_val("t5_bank5_wr", gpio_out, {32'h0, 32'hDE22BE44});
    @(negedge clk);
    addr = 24'h000000; din = 32'h12345678; be_n = 4'b0000; as = 1'b1; ws_n = 1'b0;
    gpio_in = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    ws_n = 1'b1;
    repeat (4) @(negedge clk);
    as = 1'b0;
    check_val("t5_ws_low_rst", gpio_out, 0);
    do_read(24'h000000, 32'h0, "t5_out_after_rst");

    // 6: reset in the middle of a read
    do_write(24'h00000C, 32'h00000001, 4'b0000, 1'b0);
    do_write(24'h000024, 32'h0000FFFF, 4'b0000, 1'b0);
    do_write(24'h000000, 32'hCAFEF00D, 4'b0000, 1'b0);
    gpio_in[0] = 1'b1;
    repeat (6) @(negedge clk);
    check_val("t6_irq_pre", irq, 1);
    @(negedge clk);
    addr = 24'h000000; as = 1'b1;
    repeat (3) @(negedge clk);
    rs_n = 1'b0;
    repeat (4) @(negedge clk);
    check_val("t6_oe_pre", dout_oe, 1);
    check_val("t6_dout_pre", dout, 32'hCAFEF00D);
    #2 rst = 1'b0;
    #1;
    check_val("t6_dout_rst", dout, 0);
    check_val("t6_oe_rst", dout_oe, 0);
    check_val("t6_irq_rst", irq, 0);
    check_val("t6_gpio_out_rst", gpio_out, 0);
    check_val("t6_gpio_oe_rst", gpio_oe, 0);
    rs_n = 1'b1; ws_n = 1'b1; as = 1'b0; gpio_in = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    do_read(24'h00000C, 32'h0, "t6_en_rst");
    do_read(24'h000010, 32'h0, "t6_stat_rst");
    do_read(24'h000024, 32'h0, "t6_dir_rst");
    do_write(24'h000000, 32'h13579BDF, 4'b0000, 1'b0);
    check_val("t6_out_fresh", gpio_out[31:0], 32'h13579BDF);
    do_read(24'h000000, 32'h13579BDF, "t6_rd_fresh");

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arm_bus_gpio_slave.md
Name: arm_bus_gpio_slave

Overview:
- Parametrised ARM CS5 bus slave for the TLL6219 interface; the next generation of the fixed-width register-file and port block.
- Absorbs the raw asynchronous bus signals through internal synchronisers, so the top level wires ARM_A, ARM_D, ARM_BE_B, CPLD_* directly.
- Decodes strobes by edge and provides NUM_BANKS GPIO banks, each with per-bit direction, input capture, rising-edge interrupt status (write-1-to-clear) and a combined irq line for ARM_IRQ.

Parameters:
DW, 32, bus data width and GPIO bank width; multiple of 8.
AW, 24, bus address width.
NUM_BANKS, 2, number of GPIO banks, 1..8.
SYNC_STAGES, 2, flip-flop stages on every asynchronous input, >=2.

Ports:
clk  in  1  system clock, 100 MHz (FPGA_CLK1); all logic on rising edge.
rst  in  1  asynchronous active-low reset.
addr  in  AW  raw ARM byte address.
din  in  DW  raw ARM write data.
dout  out  DW  read data toward the ARM_D tristate.
dout_oe  out  1  high while a read is active; top level drives ARM_D = dout when high.
ws_n  in  1  raw write strobe (CPLD_WS5_B), active low.
rs_n  in  1  raw read strobe (CPLD_RS5_B), active low.
be_n  in  DW/8  raw byte enables (ARM_BE_B), active low.
as  in  1  raw address strobe (CPLD_AS), active high.
gpio_in  in  NUM_BANKS*DW  raw pin inputs.
gpio_out  out  NUM_BANKS*DW  registered pin output values.
gpio_oe  out  NUM_BANKS*DW  per-bit output enable; 1 means output.
irq  out  1  registered OR of (IRQ_STAT & IRQ_EN) over all banks.

Behaviour:
- Synchronisation:
  - addr, din, be_n, ws_n, rs_n, as and gpio_in each pass through SYNC_STAGES flops.
  - Suffix _s below means the synchronised value.
- Strobe detection:
  - Registers prev_ws and prev_rs hold the last ws_n_s and rs_n_s values; both reset to 0.
  - wr_stb = prev_ws & ~ws_n_s & as_s.
  - rd_stb = prev_rs & ~rs_n_s & as_s.
  - A strobe already low when reset releases generates no access; the strobe must first return high.
- Decode:
  - idx = addr_s[AW-1:2]; bank = idx[5:3]; reg = idx[2:0].
  - Per bank: reg0 OUT (R/W), reg1 DIR (R/W), reg2 IN (read-only, synchronised pins), reg3 IRQ_EN (R/W), reg4 IRQ_STAT (read, write-1-to-clear).
  - Any other reg, bank >= NUM_BANKS, or idx[AW-3:6] != 0 is unmapped: reads return 0, writes are ignored.
- Write:
  - On wr_stb, for each byte b with be_n_s[b]==0, update that byte of the target register from din_s.
  - Register value is visible one cycle after the wr_stb cycle.
  - Writes to IN have no effect.
- Read:
  - On wr_stb-free cycles with rd_stb, dout loads the addressed register; valid one cycle after rd_stb.
  - be_n is ignored for reads; a full word is returned.
  - dout holds its value until the next rd_stb.
  - dout_oe = registered (~rs_n_s & as_s); it drops one cycle after either signal deasserts.
  - If wr_stb and rd_stb occur in the same cycle, the write executes and the read is skipped.
- GPIO:
  - gpio_out = OUT; gpio_oe = DIR.
  - edge = in_s & ~in_prev & ~DIR (input-configured bits only); in_prev resets to 0.
  - IRQ_STAT bit is set by edge regardless of IRQ_EN.
  - IRQ_STAT bit is cleared by a write of 1 to that bit with its byte enabled.
  - If a set and a clear hit the same bit in the same cycle, set wins.
  - irq is registered: one cycle after the STAT/EN change.
- Reset (asynchronous, any time, including mid-transaction):
  - All registers, dout, dout_oe, irq, gpio_out and gpio_oe go to 0.
  - All synchroniser flops go to 0.
  - Any in-flight access is abandoned.

Test Plan:
1. Full-word write, then read:
   - Write 0xDEADBEEF to bank0 OUT (addr 0x000000), be_n=0000; gpio_out[31:0]=0xDEADBEEF one cycle after wr_stb.
   - Read back: dout=0xDEADBEEF and dout_oe=1 while rs_n is low.
2. Byte-enabled write:
   - OUT=0xDEADBEEF; write 0x11223344 with be_n=1010 to addr 0x000000; result OUT=0xDE22BE44.
3. Direction and input capture:
   - Bank1 DIR (addr 0x000024) = 0x0000FFFF; drive gpio_in[63:32]=0xA5A5A5A5.
   - After SYNC_STAGES+1 cycles, reading bank1 IN (addr 0x000028) returns 0xA5A5A5A5; gpio_oe[63:32]=0x0000FFFF.
4. Interrupt:
   - Bank0 DIR=0, IRQ_EN=0x1; pulse gpio_in[0] 0->1; irq=1 within SYNC_STAGES+2 cycles; IRQ_STAT reads 0x1.
   - Write 0x1 to IRQ_STAT (addr 0x000010); irq=0 next cycle.
   - Repeat with a new edge in the same cycle as the clear; STAT stays 1.
5. Unmapped accesses and strobe rules:
   - Read addr 0x00001C or bank 5: dout=0.
   - Write to IN: no change.
   - Hold ws_n low across reset release: no write occurs.
6. Reset mid-transaction:
   - Assert rst with rs_n low and dout_oe=1; dout, dout_oe, irq and all registers read 0 immediately.
   - After release, a fresh write/read cycle works normally.
